// File: rtl/cpu_pkg.sv
// Shared MIPS core constants: word width, reset/exception PCs, $ra index.
// Also holds the next-PC source encoding and the j/jal target helper.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [WORD_W-1:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [4:0]        REG_RA     = 5'd31;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JAL,
    SEL_JR,
    SEL_HOLD,
    SEL_EXC,
    SEL_ERET
  } npc_sel_e;

  function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] cur_pc,
                                                    input logic [25:0]       idx);
    return {cur_pc[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push/pop take effect on the next edge, top/empty are combinational.
// A push when full overwrites the oldest entry; a pop when empty is ignored.
module ras_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] sp;
  logic [AW-1:0] sp_dec;
  logic [CW-1:0] count;

  assign sp_dec = sp - AW'(1);
  assign empty  = (count == '0);
  assign top    = empty ? '0 : mem[sp_dec];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + AW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && !empty) begin
      sp    <= sp_dec;
      count <= count - CW'(1);
    end
  end

  // Entries are never cleared; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) mem[sp] <= push_data;
  end

endmodule

// File: rtl/npc_ras.sv
// Registered PC with next-PC mux, exception vectoring and a jal/jr return-address stack.
// One-cycle latency from controls to pc; stall holds the PC and the stack unless an exception or eret redirects.
module npc_ras
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter int                RAS_DEPTH  = 4,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [31:0]       epc,
  input  logic              branch,
  input  logic              zero,
  input  logic [31:0]       sign_imm,
  input  logic              jal_sel,
  input  logic              link,
  input  logic [25:0]       instr_index,
  input  logic              jr_sel,
  input  logic              ret_hint,
  input  logic [31:0]       rd1,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       ras_top,
  output logic              ras_hit,
  output logic [CNT_W-1:0]  ras_miss_cnt,
  output logic              adel
);

  npc_sel_e          sel;
  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [31:0]       br_off;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic [CNT_W-1:0]  miss_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = sign_imm << 2;
  assign adel     = |pc_q[1:0];

  always_comb begin
    sel = SEL_SEQ;
    if (exc_req)              sel = SEL_EXC;
    else if (eret)            sel = SEL_ERET;
    else if (stall)           sel = SEL_HOLD;
    else if (jal_sel)         sel = SEL_JAL;
    else if (jr_sel)          sel = SEL_JR;
    else if (branch && zero)  sel = SEL_BR;
  end

  always_comb begin
    pc_d = pc_plus4;
    case (sel)
      SEL_EXC:  pc_d = EXC_VECTOR;
      SEL_ERET: pc_d = epc;
      SEL_HOLD: pc_d = pc_q;
      SEL_JAL:  pc_d = jump_target(pc_q, instr_index);
      SEL_JR:   pc_d = rd1;
      SEL_BR:   pc_d = pc_plus4 + br_off;
      default:  pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Stack traffic only when the jump itself is the selected source.
  assign ras_push = reset && (sel == SEL_JAL) && link;
  assign ras_pop  = reset && (sel == SEL_JR)  && ret_hint;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (WORD_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign ras_hit = jr_sel && ret_hint && !ras_empty && (ras_top == rd1);

  always_ff @(posedge clk) begin
    if (!reset)
      miss_q <= '0;
    else if (ras_pop && !ras_hit && (miss_q != '1))
      miss_q <= miss_q + CNT_W'(1);
  end

  assign ras_miss_cnt = miss_q;

endmodule
